// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: registered N-digit seven-segment controller with leading-zero suppression and per-digit blink.
// Define SEG_DP_EN to add per-digit decimal points (dp_in, 8 bits per digit on seg_out).
module seg_display_ctrl #(
   parameter int N_DIGITS  = 8,
   parameter int CODE_W    = 5,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         clear,
   input  logic                         load,
   input  logic [N_DIGITS*CODE_W-1:0]   digits_in,
   input  logic                         lz_en,
   input  logic [N_DIGITS-1:0]          blink_mask,
`ifdef SEG_DP_EN
   input  logic [N_DIGITS-1:0]          dp_in,
   output logic [N_DIGITS*8-1:0]        seg_out,
`else
   output logic [N_DIGITS*7-1:0]        seg_out,
`endif
   output logic                         active
);
   localparam int SEG_W = $bits(seg_out) / N_DIGITS;
   localparam int CNT_W = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
   localparam logic [6:0] HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {IDLE, SHOW} state_t;

   state_t                        state_q, state_d;
   logic [N_DIGITS*CODE_W-1:0]    digit_q, digit_d;
   logic [CNT_W-1:0]              blink_cnt_q, blink_cnt_d;
   logic                          blink_ph_q, blink_ph_d;
   logic [N_DIGITS*SEG_W-1:0]     seg_q, seg_d;
   logic                          active_q, active_d;
   logic [N_DIGITS:0]             zero_run;
   logic [N_DIGITS-1:0]           lz_blank;
   logic [N_DIGITS-1:0]           dark;
   logic                          timer_off;

   // SSeg decoder: codes 0..15 are hex glyphs, anything above is dark
   function automatic logic [6:0] sseg(input logic [CODE_W-1:0] c);
      return (c > CODE_W'(15)) ? 7'h7F : HEX[c[3:0]];
   endfunction

   // zero_run[i] is set when digits N_DIGITS-1 down to i are all zero
   assign zero_run[N_DIGITS] = 1'b1;
   for (genvar g = 0; g < N_DIGITS; g++) begin : g_lz
      assign zero_run[g] = zero_run[g+1] & (digit_q[g*CODE_W +: CODE_W] == '0);
      assign lz_blank[g] = (g != 0) & lz_en & zero_run[g];
   end

   assign dark      = {N_DIGITS{state_q != SHOW}} | (blink_mask & {N_DIGITS{blink_ph_q}});
   assign timer_off = (state_q != SHOW) | clear;

   always_comb begin
      state_d     = clear ? IDLE : (state_q == IDLE && !start) ? SHOW : state_q;
      digit_d     = clear ? '0 : load ? digits_in : digit_q;
      blink_cnt_d = (timer_off || blink_cnt_q == CNT_MAX) ? '0 : blink_cnt_q + CNT_W'(1);
      blink_ph_d  = timer_off ? 1'b0 : (blink_cnt_q == CNT_MAX) ? ~blink_ph_q : blink_ph_q;
      active_d    = (state_q == SHOW);
      seg_d       = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         seg_d[i*SEG_W +: 7] = (dark[i] || lz_blank[i]) ? 7'h7F : sseg(digit_q[i*CODE_W +: CODE_W]);
`ifdef SEG_DP_EN
         seg_d[i*SEG_W + 7] = dark[i] | ~dp_in[i];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         digit_q     <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         seg_q       <= '1;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         digit_q     <= digit_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         seg_q       <= seg_d;
         active_q    <= active_d;
      end
   end

   assign seg_out = seg_q;
   assign active  = active_q;
endmodule
